// File: rtl/bidir_link_ctrl.sv
// Half-duplex serial link controller: serializes TX words onto the switch stage
// and, on request, releases the line, waits a turnaround gap and deserializes a word.
module bidir_link_ctrl #(
  parameter int WIDTH = 8,
  parameter int TURN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             io1,
  output logic             ctrl,
  input  logic             io_in,
  output logic             busy
);

  localparam int MAXC = (WIDTH > TURN) ? WIDTH : TURN;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TLAST = CW'(TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_REL,
    S_TURN,
    S_SAMPLE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  assign tx_ready = (state == S_IDLE) && !rst;

  // One shift register serves both directions; io1 is registered, so the first
  // TX bit is loaded straight into io1 at acceptance and the rest shift out after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      io1      <= 1'b0;
      ctrl     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (tx_valid) begin
            state <= S_DRIVE;
            shreg <= tx_data >> 1;
            io1   <= tx_data[0];
            ctrl  <= 1'b1;
            busy  <= 1'b1;
          end else if (rx_req) begin
            state <= S_TURN;
            busy  <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == WLAST) begin
            state <= S_REL;
            cnt   <= '0;
            ctrl  <= 1'b0;
            io1   <= 1'b0;
          end else begin
            cnt   <= cnt + 1'b1;
            io1   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        S_REL: begin
          if (cnt == TLAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (cnt == TLAST) begin
            state <= S_SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // LSB arrives first, so each new bit enters at the MSB and walks down.
        S_SAMPLE: begin
          shreg <= {io_in, shreg[WIDTH-1:1]};
          if (cnt == WLAST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rx_data  <= {io_in, shreg[WIDTH-1:1]};
            rx_valid <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          ctrl  <= 1'b0;
          io1   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_ctrl_only_in_drive : assert property (@(posedge clk) disable iff (rst)
    ctrl |-> (state == S_DRIVE));
  a_no_rx_valid_while_driving : assert property (@(posedge clk) disable iff (rst)
    !(rx_valid && ctrl));

endmodule

// File: doc/bidir_link_ctrl.md
# bidir_link_ctrl

Half-duplex serial link controller that sits directly upstream of the `bidirectional` switch stage. It generates the stage's `io1` drive value and `ctrl` enable, and samples the shared line back through `io_in`. Parallel words are serialized onto the line LSB-first when transmitting. On request, the block releases the line, waits a turnaround gap, then deserializes a word driven by the far side. One clock domain.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `TURN`, 2: bus-release (turnaround) cycles after TX and before RX; must be ≥ 1.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_valid`  in  1: a TX word is offered.
- `tx_ready`  out  1: the block accepts a TX word this cycle.
- `tx_data`  in  WIDTH: word to transmit.
- `rx_req`  in  1: request to receive one word.
- `rx_valid`  out  1: one-cycle pulse; `rx_data` is new.
- `rx_data`  out  WIDTH: last received word, held until the next receive completes.
- `io1`  out  1: serial drive value to the switch stage.
- `ctrl`  out  1: switch enable; 1 only while the block owns the line.
- `io_in`  in  1: sampled line value (switch far side).
- `busy`  out  1: state ≠ IDLE.

## Operation
- States: IDLE, DRIVE, REL (post-TX release), TURN (pre-RX gap), SAMPLE.
- IDLE:
  - Outputs: `ctrl`=0, `io1`=0, `tx_ready`=1.
  - Handshake: `tx_valid & tx_ready` at an edge loads `tx_data` into the shift register, clears the bit counter, and moves to DRIVE.
  - Otherwise, `rx_req`=1 moves to TURN.
  - TX wins if both are asserted; `rx_req` is then ignored. The requester must hold it until `busy` falls and assert it again.
- DRIVE (WIDTH cycles):
  - `ctrl`=1 and `io1`=shift[0].
  - The register shifts right each edge.
  - After the WIDTH-th bit, go to REL.
- REL (TURN cycles): `ctrl`=0, `io1`=0, then IDLE.
- TURN (TURN cycles): `ctrl`=0, `io1`=0, then SAMPLE.
- SAMPLE (WIDTH cycles):
  - `ctrl`=0.
  - At each edge, `io_in` shifts in at the MSB (LSB-first reception).
  - After the WIDTH-th sample, go to IDLE, load `rx_data`, and pulse `rx_valid`.
- `tx_ready`=0 in every state except IDLE. `tx_data`/`tx_valid` are ignored outside IDLE.
- Counters are sized to max(WIDTH, TURN) and never wrap within a state.
- `io1`, `ctrl`, `rx_valid`, `rx_data` and `busy` are registered. `tx_ready` is decoded from state, gated by `rst`.
- Invariant: `ctrl`=1 implies state DRIVE. The line is never driven in TURN, SAMPLE or REL.

## Timing
- Reset values: `ctrl`=0, `io1`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, and `tx_ready`=0 while `rst`=1. State is IDLE, so `tx_ready`=1 in the first cycle after `rst` falls.
- TX accepted at edge k:
  - Cycles k+1..k+WIDTH: `ctrl`=1, carrying bit 0..WIDTH-1.
  - Cycles k+WIDTH+1..k+WIDTH+TURN: released.
  - Cycle k+WIDTH+TURN+1: `tx_ready`=1.
  - A back-to-back word therefore costs WIDTH+TURN+1 cycles.
- RX request sampled at edge k:
  - Cycles k+1..k+TURN: gap.
  - `io_in` sampled at the edges ending cycles k+TURN+1..k+TURN+WIDTH.
  - `rx_valid`=1 in cycle k+TURN+WIDTH+1 only. The block is in IDLE in that same cycle and can accept TX or RX.
- Reset mid-operation:
  - Abort at that edge and go to IDLE.
  - `ctrl`/`io1` go to 0 at the same edge.
  - A partial RX word is discarded and `rx_data` is cleared. No `rx_valid` is generated.
- `rx_valid` never asserts in the same cycle as `ctrl`=1.

## Test plan
(WIDTH=8, TURN=2)
- Reset: hold `rst` 3 cycles with `tx_valid`=1 -> `ctrl`=0, `io1`=0, `tx_ready`=0, `rx_data`=0x00. After release, `tx_ready`=1 and no transfer has started during reset.
- TX 0xA5 accepted at edge k -> cycles k+1..k+8 show `ctrl`=1 with `io1` = 1,0,1,0,0,1,0,1. `ctrl`=0 for 2 cycles, then `tx_ready`=1 at k+11.
- RX: `rx_req` at edge k, far side drives 0x3C LSB-first on `io_in` during cycles k+3..k+10 -> `ctrl`=0 throughout, and `rx_valid` pulses at k+11 with `rx_data`=0x3C. `rx_data` holds 0x3C afterwards.
- Simultaneous `tx_valid`(0xFF) and `rx_req` in IDLE -> TX of 0xFF runs with 8 `ctrl`=1 cycles. No sampling occurs, and no `rx_valid` appears until `rx_req` is reasserted after `busy` falls.
- Back-to-back TX with `tx_valid` held high (0x01 then 0x80) -> second acceptance exactly 11 cycles after the first, with a 2-cycle `ctrl`=0 gap between the words.
- `rst` asserted at the 4th SAMPLE cycle -> next cycle IDLE, `busy`=0, `rx_data`=0, and no `rx_valid` pulse.
